// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Holds the FSM state encoding and the memory geometry constants.
package imem_loader_pkg;

  localparam int IMEM_AW = 8;
  localparam int IMEM_DW = 16;
  localparam int CNT_W   = IMEM_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_B0,
    S_GET_B1,
    S_WRITE,
    S_DONE
  } state_e;

  // A length byte of zero stands for a full 256-word image.
  function automatic logic [CNT_W-1:0] len_decode(
    input logic [7:0] b
  );
    logic [CNT_W-1:0] r;
    if (b == 8'd0) begin
      r = {1'b1, 8'h00};
    end else begin
      r = {1'b0, b};
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_pack.sv
// Assembles two serial bytes into one instruction word.
// Holds the first byte; the second is taken live from the stream.
module byte_pack
  import imem_loader_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load_b0,
  input  logic [7:0]         i_byte,
  output logic [IMEM_DW-1:0] o_word
);

  logic [7:0] r_b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b0 <= 8'h00;
    end else if (i_load_b0) begin
      r_b0 <= i_byte;
    end
  end

  // Word is valid in the cycle the second byte is transferred.
  always_comb begin
    o_word = '0;
    if (HI_FIRST) begin
      o_word = {r_b0, i_byte};
    end else begin
      o_word = {i_byte, r_b0};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory,
// then releases the processor by raising cpu_run.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter bit         HI_FIRST  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               we,
  output logic [IMEM_AW-1:0] new_instruction_address,
  output logic [IMEM_DW-1:0] instruction_in,
  output logic               cpu_run,
  output logic               busy,
  output logic [CNT_W-1:0]   words_loaded
);

  state_e r_state;
  state_e w_state_nxt;

  logic               r_we;
  logic [IMEM_AW-1:0] r_addr;
  logic [IMEM_DW-1:0] r_data;
  logic [CNT_W-1:0]   r_wl;
  logic [CNT_W-1:0]   r_len;

  logic               w_ready;
  logic               w_xfer;
  logic               w_start_ok;
  logic               w_load_b0;
  logic               w_write_nxt;
  logic               w_len_load;
  logic [CNT_W-1:0]   w_wl_inc;
  logic [IMEM_DW-1:0] w_word;

  byte_pack #(
    .HI_FIRST (HI_FIRST)
  ) u_pack (
    .clk       (clk),
    .reset     (reset),
    .i_load_b0 (w_load_b0),
    .i_byte    (byte_in),
    .o_word    (w_word)
  );

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_GET_LEN,
      S_GET_B0,
      S_GET_B1: w_ready = 1'b1;
      default:  w_ready = 1'b0;
    endcase
  end

  assign w_xfer   = byte_valid && w_ready;
  assign w_wl_inc = r_wl + 1'b1;

  assign w_start_ok  = start && !abort &&
                       (r_state == S_IDLE ||
                        r_state == S_DONE);
  assign w_load_b0   = (r_state == S_GET_B0) &&
                       w_xfer && !abort;
  assign w_write_nxt = (r_state == S_GET_B1) &&
                       w_xfer && !abort;
  assign w_len_load  = (r_state == S_GET_LEN) &&
                       w_xfer && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort overrides every other transition, including start in DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          w_state_nxt = S_GET_B0;
        end
      end
      S_GET_B0: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          w_state_nxt = S_GET_B1;
        end
      end
      S_GET_B1: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_wl_inc == r_len) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_GET_B0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write strobe and data are set up one edge ahead of WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_wl   <= '0;
      r_len  <= '0;
    end else begin
      r_we   <= w_write_nxt;
      r_data <= w_write_nxt ? w_word : '0;
      if (w_write_nxt) begin
        r_addr <= BASE_ADDR + r_wl[IMEM_AW-1:0];
      end
      if (w_start_ok) begin
        r_wl <= '0;
      end else if (r_state == S_WRITE) begin
        r_wl <= w_wl_inc;
      end
      if (w_len_load) begin
        r_len <= len_decode(byte_in);
      end
    end
  end

  assign byte_ready              = w_ready;
  assign we                      = r_we;
  assign new_instruction_address = r_addr;
  assign instruction_in          = r_data;
  assign words_loaded            = r_wl;
  assign cpu_run                 = (r_state == S_DONE);
  assign busy                    = (r_state != S_IDLE) &&
                                   (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at
// stimulus time and popped by a monitor on every we pulse.
module tb_imem_loader;

  localparam logic [7:0] BASE = 8'h10;
  localparam bit         HI   = 1'b1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        cpu_run;
  logic        busy;
  logic [8:0]  wl;

  imem_loader #(
    .BASE_ADDR (BASE),
    .HI_FIRST  (HI)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .abort                   (abort),
    .byte_in                 (byte_in),
    .byte_valid              (byte_valid),
    .byte_ready              (byte_ready),
    .we                      (we),
    .new_instruction_address (addr),
    .instruction_in          (data),
    .cpu_run                 (cpu_run),
    .busy                    (busy),
    .words_loaded            (wl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_checks;
  int         n_errors;
  int         we_count;
  logic [7:0] last_addr;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [7:0] b0,
                                       input logic [7:0] b1);
    return HI ? {b0, b1} : {b1, b0};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        wr_t e;
        we_count++;
        last_addr = addr;
        chk("ready_in_write", {31'd0, byte_ready}, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_we: addr %0h data %0h, none expected",
                   addr, data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, addr}, {24'd0, e.a});
          chk("wr_data", {16'd0, data}, {16'd0, e.d});
        end
      end else begin
        chk("data_zero_idle", {16'd0, data}, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in = b;
        acc = byte_ready;
      end
      @(posedge clk);
      #1;
      t++;
    end
    byte_valid = 1'b0;
    chk("byte_accept", {31'd0, acc}, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_cpu_run", {31'd0, cpu_run}, 0);
    chk("start_wl_clear", {23'd0, wl}, 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!cpu_run && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_reached", {31'd0, cpu_run}, 1);
  endtask

  task automatic run_load(input logic [7:0] len, input bit gaps);
    int nw;
    nw = (len == 8'd0) ? 256 : int'(len);
    pulse_start();
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back('{a: 8'(BASE + 8'(i)),
                        d: pack(stim[2*i], stim[2*i+1])});
    end
    send_byte(len, gaps);
    for (int i = 0; i < 2 * nw; i++) begin
      send_byte(stim[i], gaps);
    end
    wait_done();
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) begin
      stim.push_back(8'($urandom));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 0);
    chk({tag, "_addr"}, {24'd0, addr}, 0);
    chk({tag, "_data"}, {16'd0, data}, 0);
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_wl"}, {23'd0, wl}, 0);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 0);
  endtask

  int w0;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    we_count   = 0;
    last_addr  = 8'h00;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #3;
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fixed two-word image
    stim.delete();
    stim.push_back(8'h12);
    stim.push_back(8'h34);
    stim.push_back(8'hAB);
    stim.push_back(8'hCD);
    run_load(8'd2, 1'b0);
    chk("a_wl", {23'd0, wl}, 2);
    chk("a_busy", {31'd0, busy}, 0);
    chk("a_queue", exp_q.size(), 0);

    // Three words with random valid gaps, reload from DONE
    fill_random(6);
    run_load(8'd3, 1'b1);
    chk("b_wl", {23'd0, wl}, 3);
    chk("b_queue", exp_q.size(), 0);

    // Full 256-word image wraps the address
    fill_random(512);
    w0 = we_count;
    run_load(8'd0, 1'b0);
    chk("c_wl", {23'd0, wl}, 256);
    chk("c_we_count", we_count - w0, 256);
    chk("c_last_addr", {24'd0, last_addr}, 32'h0F);
    chk("c_queue", exp_q.size(), 0);

    // Abort after first byte of word 2
    fill_random(4);
    w0 = we_count;
    pulse_start();
    send_byte(8'd5, 1'b0);
    exp_q.push_back('{a: BASE, d: pack(stim[0], stim[1])});
    send_byte(stim[0], 1'b0);
    send_byte(stim[1], 1'b0);
    send_byte(stim[2], 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("d_busy", {31'd0, busy}, 0);
    chk("d_cpu_run", {31'd0, cpu_run}, 0);
    chk("d_wl", {23'd0, wl}, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("d_we_count", we_count - w0, 1);
    chk("d_queue", exp_q.size(), 0);

    // Asynchronous reset while in GET_B1
    fill_random(4);
    w0 = we_count;
    pulse_start();
    send_byte(8'd4, 1'b0);
    exp_q.push_back('{a: BASE, d: pack(stim[0], stim[1])});
    send_byte(stim[0], 1'b0);
    send_byte(stim[1], 1'b0);
    send_byte(stim[2], 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("e_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("e_we_count", we_count - w0, 1);
    chk("e_queue", exp_q.size(), 0);
    fill_random(4);
    run_load(8'd2, 1'b1);
    chk("e_reload_wl", {23'd0, wl}, 2);
    chk("e_reload_queue", exp_q.size(), 0);

    // start and abort together in DONE
    w0 = we_count;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("f_cpu_run", {31'd0, cpu_run}, 0);
    chk("f_busy", {31'd0, busy}, 0);
    chk("f_wl_hold", {23'd0, wl}, 2);
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      chk("f_ready_idle", {31'd0, byte_ready}, 0);
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    chk("f_busy_after", {31'd0, busy}, 0);
    chk("f_we_count", we_count - w0, 0);
    chk("f_wl_after", {23'd0, wl}, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
